// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the memory-stage load/store unit.
// Misaligned-op trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      MASK_NONE = 2'b00,
      MASK_SB   = 2'b01,
      MASK_SH   = 2'b10,
      MASK_SW   = 2'b11
   } mask_t;

   typedef enum logic [1:0] {
      LD_WORD = 2'b00,
      LD_BYTE = 2'b01,
      LD_HALF = 2'b10
   } lblh_t;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

   // Load controls captured at accept and replayed when the response returns
   typedef struct packed {
      lblh_t      kind;
      logic       uns;
      logic [1:0] a;
   } ld_op_t;

   // Big-endian lanes: byte offset 0 is bits [31:24]
   function automatic logic [3:0] store_wen(input mask_t m, input logic [1:0] a);
      case (m)
         MASK_SB: return 4'b1000 >> a;
         MASK_SH: return a[1] ? 4'b0011 : 4'b1100;
         MASK_SW: return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] store_wdata(input mask_t m, input logic [31:0] wd);
      case (m)
         MASK_SB: return {4{wd[7:0]}};
         MASK_SH: return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

   function automatic logic misaligned(input logic st, input mask_t m, input lblh_t k,
                                       input logic [1:0] a);
      if (st)
         return (m == MASK_SH && a[0]) || (m == MASK_SW && a != 2'b00);
      return (k == LD_HALF && a[0]) || (k != LD_BYTE && k != LD_HALF && a != 2'b00);
   endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Combinational big-endian lane select with sign/zero extension.
// Shared with the W-stage bypass path, so it carries no state.
module lsu_load_extract
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  ld_op_t      op,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      case (op.a)
         2'd0: byte_sel = rdata[31:24];
         2'd1: byte_sel = rdata[23:16];
         2'd2: byte_sel = rdata[15:8];
         2'd3: byte_sel = rdata[7:0];
         default: byte_sel = 8'h00;
      endcase
      half_sel = op.a[1] ? rdata[15:0] : rdata[31:16];

      result = rdata;
      case (op.kind)
         LD_BYTE: result = {{24{byte_sel[7] & ~op.uns}}, byte_sel};
         LD_HALF: result = {{16{half_sel[15] & ~op.uns}}, half_sel};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/lsu_align.sv
// Memory-stage LSU: registers one op, drives a valid/ready memory request, returns extended loads.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned SH/LH/SW/LW instead of issuing them.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int unsigned RESP_TIMEOUT = 255,
   parameter int unsigned ADDR_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ReqValidE,
   output logic                  ReqReadyE,
   input  logic                  MemReadE,
   input  logic                  MemWriteE,
   input  logic [1:0]            MaskControlE,
   input  logic [1:0]            LBLHEnableE,
   input  logic                  LoadUnsignedE,
   input  logic [ADDR_WIDTH-1:0] AddrE,
   input  logic [31:0]           WriteDataE,
   output logic                  MemReqValid,
   input  logic                  MemReqReady,
   output logic [ADDR_WIDTH-1:0] MemAddr,
   output logic [3:0]            MemWEn,
   output logic [31:0]           MemWData,
   output logic                  MemRen,
   input  logic                  MemRespValid,
   input  logic [31:0]           MemRData,
   output logic [31:0]           LoadDataM,
   output logic                  LoadValidM,
   output logic                  StallM,
   output logic [1:0]            ErrM
);

   localparam int unsigned CW = (RESP_TIMEOUT > 0) ? $clog2(RESP_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_LAST = (RESP_TIMEOUT > 0) ? CW'(RESP_TIMEOUT - 1) : '0;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q;
   ld_op_t        op_q;
   logic [31:0]   ld_result;

   logic accept, is_store, is_load, misalign, timeout;

   assign accept   = (state_q == S_IDLE) && ReqValidE;
   assign is_store = MemWriteE;
   assign is_load  = MemReadE && !MemWriteE;

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign = (is_store || is_load) &&
                     misaligned(is_store, mask_t'(MaskControlE), lblh_t'(LBLHEnableE), AddrE[1:0]);
`else
   assign misalign = 1'b0;
`endif

   // Fires on the last allowed WAIT cycle; a response in that cycle still wins
   assign timeout = (RESP_TIMEOUT != 0) && (cnt_q == TO_LAST);

   // Gated by reset so every output reads 0 while reset is held
   assign ReqReadyE = rst_n && (state_q == S_IDLE);
   assign StallM    = (state_q != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept && (is_store || is_load) && !misalign) state_d = S_REQ;
         S_REQ:  if (MemReqReady) state_d = MemRen ? S_WAIT : S_IDLE;
         S_WAIT: if (MemRespValid || timeout) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   lsu_load_extract u_extract (
      .rdata  (MemRData),
      .op     (op_q),
      .result (ld_result)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         MemReqValid <= 1'b0;
         MemAddr     <= '0;
         MemWEn      <= 4'b0000;
         MemWData    <= 32'h0;
         MemRen      <= 1'b0;
         LoadDataM   <= 32'h0;
         LoadValidM  <= 1'b0;
         ErrM        <= ERR_NONE;
         cnt_q       <= '0;
         op_q        <= '0;
      end else begin
         LoadValidM <= 1'b0;
         ErrM       <= ERR_NONE;
         case (state_q)
            S_IDLE: begin
               if (accept && misalign) begin
                  ErrM <= ERR_MISALIGN;
               end else if (accept && (is_store || is_load)) begin
                  MemReqValid <= 1'b1;
                  MemAddr     <= {AddrE[ADDR_WIDTH-1:2], 2'b00};
                  MemWEn      <= is_store ? store_wen(mask_t'(MaskControlE), AddrE[1:0]) : 4'b0000;
                  MemWData    <= is_store ? store_wdata(mask_t'(MaskControlE), WriteDataE) : 32'h0;
                  MemRen      <= is_load;
                  op_q        <= '{kind: lblh_t'(LBLHEnableE), uns: LoadUnsignedE, a: AddrE[1:0]};
               end
            end
            S_REQ: begin
               if (MemReqReady) begin
                  MemReqValid <= 1'b0;
                  MemAddr     <= '0;
                  MemWEn      <= 4'b0000;
                  MemWData    <= 32'h0;
                  MemRen      <= 1'b0;
                  cnt_q       <= '0;
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_q + 1'b1;
               if (MemRespValid) begin
                  LoadDataM  <= ld_result;
                  LoadValidM <= 1'b1;
               end else if (timeout) begin
                  LoadDataM <= 32'h0;
                  ErrM      <= ERR_TIMEOUT;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align; inputs change and outputs are sampled on the falling edge.
module tb_lsu_align;

   localparam int unsigned AW = 32;
   localparam int unsigned TO = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ReqValidE = 1'b0, MemReadE = 1'b0, MemWriteE = 1'b0, LoadUnsignedE = 1'b0;
   logic [1:0]    MaskControlE = 2'b00, LBLHEnableE = 2'b00;
   logic [AW-1:0] AddrE = '0;
   logic [31:0]   WriteDataE = 32'h0;
   logic          ReqReadyE, MemReqValid, MemRen, LoadValidM, StallM;
   logic          MemReqReady = 1'b0, MemRespValid = 1'b0;
   logic [AW-1:0] MemAddr;
   logic [3:0]    MemWEn;
   logic [31:0]   MemWData, LoadDataM;
   logic [31:0]   MemRData = 32'h0;
   logic [1:0]    ErrM;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   lsu_align #(.RESP_TIMEOUT(TO), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .ReqValidE(ReqValidE), .ReqReadyE(ReqReadyE),
      .MemReadE(MemReadE), .MemWriteE(MemWriteE),
      .MaskControlE(MaskControlE), .LBLHEnableE(LBLHEnableE), .LoadUnsignedE(LoadUnsignedE),
      .AddrE(AddrE), .WriteDataE(WriteDataE),
      .MemReqValid(MemReqValid), .MemReqReady(MemReqReady),
      .MemAddr(MemAddr), .MemWEn(MemWEn), .MemWData(MemWData), .MemRen(MemRen),
      .MemRespValid(MemRespValid), .MemRData(MemRData),
      .LoadDataM(LoadDataM), .LoadValidM(LoadValidM), .StallM(StallM), .ErrM(ErrM)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Presents one op for a single cycle; returns on the falling edge after accept
   task automatic issue(input logic rd, input logic wr, input logic [1:0] mask,
                        input logic [1:0] lblh, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
      ReqValidE = 1'b1; MemReadE = rd; MemWriteE = wr; MaskControlE = mask;
      LBLHEnableE = lblh; LoadUnsignedE = uns; AddrE = addr; WriteDataE = wd;
      @(negedge clk);
      ReqValidE = 1'b0; MemReadE = 1'b0; MemWriteE = 1'b0;
   endtask

   task automatic store_op(input string tag, input logic rd, input logic [1:0] mask,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] wen, input logic [31:0] wdata, input logic chk_data);
      MemReqReady = 1'b1;
      issue(rd, 1'b1, mask, 2'b00, 1'b0, addr, wd);
      chk({tag, ".valid"}, 32'(MemReqValid), 1);
      chk({tag, ".ren"},   32'(MemRen), 0);
      chk({tag, ".addr"},  MemAddr, {addr[31:2], 2'b00});
      chk({tag, ".wen"},   32'(MemWEn), 32'(wen));
      if (chk_data) chk({tag, ".wdata"}, MemWData, wdata);
      chk({tag, ".stall"}, 32'(StallM), 1);
      @(negedge clk);
      chk({tag, ".done_valid"}, 32'(MemReqValid), 0);
      chk({tag, ".done_stall"}, 32'(StallM), 0);
      chk({tag, ".no_ldv0"},    32'(LoadValidM), 0);
      @(negedge clk);
      chk({tag, ".no_ldv1"},    32'(LoadValidM), 0);
   endtask

   // Ready and response each arrive the first cycle they are looked for
   task automatic load_op(input string tag, input logic [1:0] lblh, input logic uns,
                          input logic [31:0] addr, input logic [31:0] rdata, input logic [31:0] exp);
      MemReqReady = 1'b1;
      issue(1'b1, 1'b0, 2'b00, lblh, uns, addr, 32'h0);
      chk({tag, ".valid"}, 32'(MemReqValid), 1);
      chk({tag, ".ren"},   32'(MemRen), 1);
      chk({tag, ".wen"},   32'(MemWEn), 0);
      chk({tag, ".addr"},  MemAddr, {addr[31:2], 2'b00});
      @(negedge clk);
      chk({tag, ".wait_stall"}, 32'(StallM), 1);
      chk({tag, ".wait_ldv"},   32'(LoadValidM), 0);
      MemRespValid = 1'b1; MemRData = rdata;
      @(negedge clk);
      MemRespValid = 1'b0; MemRData = 32'h0;
      chk({tag, ".ldv"},   32'(LoadValidM), 1);
      chk({tag, ".data"},  LoadDataM, exp);
      chk({tag, ".err"},   32'(ErrM), 0);
      chk({tag, ".stall"}, 32'(StallM), 0);
      @(negedge clk);
      chk({tag, ".ldv_pulse"}, 32'(LoadValidM), 0);
      chk({tag, ".hold"},      LoadDataM, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      #12;
      chk("rst.ready", 32'(ReqReadyE), 0);
      chk("rst.valid", 32'(MemReqValid), 0);
      chk("rst.stall", 32'(StallM), 0);
      chk("rst.data",  LoadDataM, 0);
      chk("rst.err",   32'(ErrM), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle.ready", 32'(ReqReadyE), 1);
      chk("idle.stall", 32'(StallM), 0);

      // Stores: SB lane, SW, mask-none, read+write (store wins)
      store_op("sb",   1'b0, 2'b01, 32'h1002, 32'h000000AB, 4'b0010, 32'hABABABAB, 1'b1);
      store_op("sw",   1'b0, 2'b11, 32'h3004, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 1'b1);
      store_op("snone",1'b0, 2'b00, 32'h6003, 32'h11223344, 4'b0000, 32'h0, 1'b0);
      store_op("rw",   1'b1, 2'b01, 32'h7000, 32'h0000005A, 4'b1000, 32'h5A5A5A5A, 1'b1);

      // Neither read nor write: consumed without a request
      issue(1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 32'h8000, 32'h0);
      chk("nop.valid", 32'(MemReqValid), 0);
      chk("nop.stall", 32'(StallM), 0);

      // Loads from one read word 0x1280FF34
      load_op("lb",   2'b01, 1'b0, 32'h1001, 32'h1280FF34, 32'hFFFFFF80);
      load_op("lbu",  2'b01, 1'b1, 32'h1001, 32'h1280FF34, 32'h00000080);
      load_op("lb3",  2'b01, 1'b0, 32'h1003, 32'h1280FF34, 32'h00000034);
      load_op("lhu",  2'b10, 1'b1, 32'h1002, 32'h1280FF34, 32'h0000FF34);
      load_op("lh",   2'b10, 1'b0, 32'h1002, 32'h1280FF34, 32'hFFFFFF34);
      load_op("lh0",  2'b10, 1'b0, 32'h1000, 32'h1280FF34, 32'h00001280);
      load_op("lw",   2'b00, 1'b0, 32'h1000, 32'h1280FF34, 32'h1280FF34);

      // SH with memory back-pressure for 5 cycles
      MemReqReady = 1'b0;
      issue(1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 32'h2000, 32'h1234CAFE);
      for (int i = 0; i < 5; i++) begin
         chk("bp.valid", 32'(MemReqValid), 1);
         chk("bp.addr",  MemAddr, 32'h2000);
         chk("bp.wen",   32'(MemWEn), 32'hC);
         chk("bp.wdata", MemWData, 32'hCAFECAFE);
         chk("bp.stall", 32'(StallM), 1);
         chk("bp.ready", 32'(ReqReadyE), 0);
         if (i == 4) MemReqReady = 1'b1;
         @(negedge clk);
      end
      chk("bp.done_valid", 32'(MemReqValid), 0);
      chk("bp.done_ready", 32'(ReqReadyE), 1);

      // Timeout: LW with no response
      issue(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 32'h4000, 32'h0);
      @(negedge clk);
      k = 0;
      while (ErrM == 2'b00 && k < 12) begin
         @(negedge clk);
         k++;
      end
      chk("to.err",    32'(ErrM), 2);
      chk("to.cycles", 32'(k), TO);
      chk("to.data",   LoadDataM, 0);
      chk("to.ldv",    32'(LoadValidM), 0);
      chk("to.stall",  32'(StallM), 0);
      chk("to.ready",  32'(ReqReadyE), 1);
      @(negedge clk);
      chk("to.pulse",  32'(ErrM), 0);

      // Response on the timeout cycle wins
      issue(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 32'h4000, 32'h0);
      @(negedge clk);
      repeat (TO - 1) @(negedge clk);
      MemRespValid = 1'b1; MemRData = 32'hDEADBEEF;
      @(negedge clk);
      MemRespValid = 1'b0;
      chk("race.ldv",  32'(LoadValidM), 1);
      chk("race.data", LoadDataM, 32'hDEADBEEF);
      chk("race.err",  32'(ErrM), 0);

      // Unaligned LW
`ifdef LSU_MISALIGN_TRAP_EN
      issue(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 32'h3002, 32'h0);
      chk("mis.err",   32'(ErrM), 1);
      chk("mis.stall", 32'(StallM), 0);
      for (int i = 0; i < 3; i++) begin
         chk("mis.valid", 32'(MemReqValid), 0);
         @(negedge clk);
      end
      chk("mis.pulse", 32'(ErrM), 0);
`else
      load_op("lw_unal", 2'b00, 1'b0, 32'h3002, 32'h55AA33CC, 32'h55AA33CC);
`endif

      // Reset while waiting for a response
      MemReqReady = 1'b1;
      issue(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 32'h5000, 32'h0);
      @(negedge clk);
      chk("rw.stall_before", 32'(StallM), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rw.stall", 32'(StallM), 0);
      chk("rw.ready", 32'(ReqReadyE), 0);
      chk("rw.valid", 32'(MemReqValid), 0);
      chk("rw.addr",  MemAddr, 0);
      chk("rw.data",  LoadDataM, 0);
      chk("rw.err",   32'(ErrM), 0);
      @(negedge clk);
      rst_n = 1'b1;
      MemRespValid = 1'b1; MemRData = 32'h12345678;
      @(negedge clk);
      MemRespValid = 1'b0;
      chk("late.ldv",   32'(LoadValidM), 0);
      chk("late.data",  LoadDataM, 0);
      chk("late.stall", 32'(StallM), 0);
      @(negedge clk);
      chk("late.ldv2",  32'(LoadValidM), 0);
      chk("late.ready", 32'(ReqReadyE), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
